cmpp_eq_arb: RTL and testbench

//  Shares one equality compare-to-predicate unit (existing cmpp_eq_1) among NREQ requesters.

---
 rtl/cmpp_eq_arb_pkg.sv | 28 ++
 rtl/cmpp_eq_1.sv | 33 +++
 rtl/cmpp_eq_arb.sv | 135 +++++++++++++
 tb/tb_cmpp_eq_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmpp_eq_arb_pkg.sv
// Shared types and op encodings for the arbitrated equality compare-to-predicate unit.
package cmpp_eq_arb_pkg;

  localparam int unsigned OP_W = 3;

  // Op encodings: bit1 inverts o0, bit0 inverts o1, bit2 set means no-op.
  localparam logic [OP_W-1:0] CMPP_OP_NN = 3'b000;
  localparam logic [OP_W-1:0] CMPP_OP_NI = 3'b001;
  localparam logic [OP_W-1:0] CMPP_OP_IN = 3'b010;
  localparam logic [OP_W-1:0] CMPP_OP_II = 3'b011;
  localparam int unsigned     CMPP_OP_NOP_BIT = 2;

  // Pipeline occupancy, encoded as {s1_vld, rsp_valid}.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_OUT   = 2'b01,
    OCC_S1    = 2'b10,
    OCC_BOTH  = 2'b11
  } occ_t;

  typedef struct packed {
    logic o0;
    logic o1;
    logic o0_en;
    logic o1_en;
  } cmpp_res_t;

endpackage

// File: rtl/cmpp_eq_1.sv
// Combinational equality compare-to-predicate: two predicate results plus write-enables.
module cmpp_eq_1
  import cmpp_eq_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [OP_W-1:0]  op,
  input  logic             pred,
  output cmpp_res_t        res_c
);

  logic eq;

  assign eq = (i0 == i1);

  always_comb begin
    res_c       = '0;
    res_c.o0_en = 1'b1;
    res_c.o1_en = 1'b1;
    if (pred && !op[CMPP_OP_NOP_BIT]) begin
      unique case (op)
        CMPP_OP_NN: begin res_c.o0 = eq;  res_c.o1 = eq;  end
        CMPP_OP_NI: begin res_c.o0 = eq;  res_c.o1 = ~eq; end
        CMPP_OP_IN: begin res_c.o0 = ~eq; res_c.o1 = eq;  end
        CMPP_OP_II: begin res_c.o0 = ~eq; res_c.o1 = ~eq; end
        default:    begin res_c.o0 = 1'b0; res_c.o1 = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/cmpp_eq_arb.sv
// Round-robin arbiter sharing one cmpp_eq_1 among NREQ requesters through a
// two-stage (operand, result) pipeline with valid/ready backpressure on the result.
module cmpp_eq_arb
  import cmpp_eq_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_i0,
  input  logic [NREQ*WIDTH-1:0] req_i1,
  input  logic [NREQ*OP_W-1:0]  req_op,
  input  logic [NREQ-1:0]       req_pred,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_o0,
  output logic                  rsp_o1,
  output logic                  rsp_o0_en,
  output logic                  rsp_o1_en
);

  occ_t             occ_q, occ_d;
  logic             s1_vld;
  logic             adv_out, issue_ok, grant;
  logic             pick_vld;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   rr_ptr;

  logic [WIDTH-1:0] s1_i0, s1_i1;
  logic [OP_W-1:0]  s1_op;
  logic             s1_pred;
  logic [IDW-1:0]   s1_id;

  cmpp_res_t        cmp_res_c, res_q;
  logic [IDW-1:0]   id_q;

  // First requester at or after ptr (mod NREQ); walking offsets high-to-low lets the nearest win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] ptr);
    logic [IDW:0]   sel;
    logic [IDW-1:0] k;
    int unsigned    idx;
    sel = '0;
    for (int unsigned off = NREQ; off > 0; off--) begin
      idx = (32'(ptr) + off - 32'd1) % NREQ;
      k   = IDW'(idx);
      if (r[k]) sel = {1'b1, k};
    end
    return sel;
  endfunction

  assign s1_vld    = occ_q[1];
  assign rsp_valid = occ_q[0];

  always_comb begin
    {pick_vld, pick_idx} = rr_pick(req, rr_ptr);
    adv_out  = s1_vld & (~rsp_valid | rsp_ready);
    issue_ok = ~s1_vld | adv_out;
    grant    = reset_n & issue_ok & pick_vld;
    gnt      = grant ? (NREQ'(1) << pick_idx) : '0;
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!reset_n) occ_q <= OCC_EMPTY;
    else          occ_q <= occ_d;
  end

  // Occupancy next state: s1 fills on grant and drains on adv_out; output drains on rsp_ready.
  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: occ_d = grant ? OCC_S1 : OCC_EMPTY;
      OCC_S1:    occ_d = grant ? OCC_BOTH : OCC_OUT;
      OCC_OUT: begin
        if (grant) occ_d = rsp_ready ? OCC_S1 : OCC_BOTH;
        else       occ_d = rsp_ready ? OCC_EMPTY : OCC_OUT;
      end
      OCC_BOTH: begin
        if (rsp_ready) occ_d = grant ? OCC_BOTH : OCC_OUT;
        else           occ_d = OCC_BOTH;
      end
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Operand stage and round-robin pointer; operands are sampled only on the grant edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_i0   <= '0;
      s1_i1   <= '0;
      s1_op   <= '0;
      s1_pred <= 1'b0;
      s1_id   <= '0;
      rr_ptr  <= '0;
    end else if (grant) begin
      s1_i0   <= req_i0[pick_idx*WIDTH +: WIDTH];
      s1_i1   <= req_i1[pick_idx*WIDTH +: WIDTH];
      s1_op   <= req_op[pick_idx*OP_W +: OP_W];
      s1_pred <= req_pred[pick_idx];
      s1_id   <= pick_idx;
      rr_ptr  <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  cmpp_eq_1 #(.WIDTH(WIDTH)) u_cmpp (
    .i0    (s1_i0),
    .i1    (s1_i1),
    .op    (s1_op),
    .pred  (s1_pred),
    .res_c (cmp_res_c)
  );

  // Result stage holds while stalled and only reloads when s1 advances.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q <= '0;
      id_q  <= '0;
    end else if (adv_out) begin
      res_q <= cmp_res_c;
      id_q  <= s1_id;
    end
  end

  assign rsp_id    = id_q;
  assign rsp_o0    = res_q.o0;
  assign rsp_o1    = res_q.o1;
  assign rsp_o0_en = res_q.o0_en;
  assign rsp_o1_en = res_q.o1_en;

endmodule

// File: tb/tb_cmpp_eq_arb.sv
// Scoreboard bench for cmpp_eq_arb: expected responses are queued at grant time and
// matched in order against responses accepted on the output handshake.
module tb_cmpp_eq_arb;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           o0;
    logic           o1;
    logic           o0_en;
    logic           o1_en;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_i0, req_i1;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ-1:0]       req_pred;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_o0, rsp_o1, rsp_o0_en, rsp_o1_en;

  rsp_t            exp_q[$];
  rsp_t            obs_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [NREQ-1:0] last_gnt;
  logic            last_valid;
  rsp_t            last_rsp;
  rsp_t            o, e;

  always #5 clk = ~clk;

  cmpp_eq_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_i0    (req_i0),
    .req_i1    (req_i1),
    .req_op    (req_op),
    .req_pred  (req_pred),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o0    (rsp_o0),
    .rsp_o1    (rsp_o1),
    .rsp_o0_en (rsp_o0_en),
    .rsp_o1_en (rsp_o1_en)
  );

  // Reference predicate semantics: {o0, o1}.
  function automatic logic [1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [2:0] op, input logic p);
    logic eq;
    eq = (a == b);
    if (op[2] || !p) return 2'b00;
    return {eq ^ op[1], eq ^ op[0]};
  endfunction

  task automatic set_lane(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] op, input logic p);
    req_i0[k*WIDTH +: WIDTH] = a;
    req_i1[k*WIDTH +: WIDTH] = b;
    req_op[k*3 +: 3]         = op;
    req_pred[k]              = p;
  endtask

  // One clock: sample at negedge, queue expectations on grant and observations on handshake.
  task automatic tick();
    logic [1:0] m;
    @(negedge clk);
    last_gnt   = gnt;
    last_valid = rsp_valid;
    last_rsp   = {rsp_id, rsp_o0, rsp_o1, rsp_o0_en, rsp_o1_en};
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) obs_q.push_back(last_rsp);
      for (int k = 0; k < int'(NREQ); k++) begin
        if (gnt[k]) begin
          m = model(req_i0[k*WIDTH +: WIDTH], req_i1[k*WIDTH +: WIDTH], req_op[k*3 +: 3], req_pred[k]);
          exp_q.push_back({IDW'(k), m, 2'b11});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req       = '1;
    req_i0    = '0;
    req_i1    = '0;
    req_op    = '0;
    req_pred  = '1;
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({last_gnt, last_valid, last_rsp} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%b valid=%b rsp=%h, expected all zero", last_gnt, last_valid, last_rsp);
      end
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (last_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_gnt: gnt=%b, expected 0001", last_gnt);
    end
    req = '0;
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    set_lane(2, 4'h5, 4'h5, 3'b000, 1'b1);
    req       = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (last_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b, expected 0100", last_gnt);
    end
    req = '0;
    tick();
    n_checks++;
    if (last_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t1: rsp_valid=%b, expected 0", last_valid);
    end
    tick();
    n_checks++;
    if ({last_valid, last_rsp} !== {1'b1, 2'd2, 4'b1111}) begin
      n_fail++;
      $display("FAIL single_t2: valid=%b rsp=%h, expected valid=1 id=2 o0=1 o1=1 en=11", last_valid, last_rsp);
    end
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL single_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [6];
    logic [WIDTH-1:0] a;
    seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < int'(NREQ); k++) begin
      a = WIDTH'($urandom_range(0, 15));
      set_lane(k, a, ($urandom_range(0, 1) == 0) ? a : WIDTH'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    req       = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (last_gnt !== seq[i]) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: gnt=%b, expected %b", i, last_gnt, seq[i]);
      end
    end
    req = '0;
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rr_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rr_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    rsp_t held;
    rsp_ready = 1'b0;
    req       = '1;
    tick();
    n_checks++;
    if (last_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_gnt0: gnt=%b, expected 0010", last_gnt);
    end
    tick();
    n_checks++;
    if (last_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_gnt1: gnt=%b, expected 0100", last_gnt);
    end
    held = exp_q[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({last_gnt, last_valid, last_rsp} !== {4'b0000, 1'b1, held}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: gnt=%b valid=%b rsp=%h, expected gnt=0000 valid=1 rsp=%h",
                 i, last_gnt, last_valid, last_rsp, held);
      end
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (last_gnt !== 4'b1000 || obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL bp_release: gnt=%b retired=%0d, expected gnt=1000 retired=1", last_gnt, obs_q.size());
    end
    rsp_ready = 1'b0;
    tick();
    n_checks++;
    if (last_gnt !== 4'b0000 || last_rsp.id !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_restall: gnt=%b id=%0d, expected gnt=0000 id=2", last_gnt, last_rsp.id);
    end
    rsp_ready = 1'b1;
    req       = '0;
    repeat (4) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bp_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_ops();
    logic [2:0] ops [3];
    logic [1:0] tbl [3];
    logic [1:0] want;
    ops = '{3'b001, 3'b011, 3'b100};
    tbl = '{2'b01, 2'b11, 2'b00};
    rsp_ready = 1'b1;
    for (int p = 1; p >= 0; p--) begin
      for (int j = 0; j < 3; j++) begin
        set_lane(0, 4'hA, 4'h3, ops[j], 1'(p));
        want = (p == 1) ? tbl[j] : 2'b00;
        req  = 4'b0001;
        tick();
        n_checks++;
        if (last_gnt !== 4'b0001) begin
          n_fail++;
          $display("FAIL ops_gnt: gnt=%b, expected 0001", last_gnt);
        end
        req = '0;
        repeat (2) tick();
        n_checks++;
        if ({last_valid, last_rsp} !== {1'b1, 2'd0, want, 2'b11}) begin
          n_fail++;
          $display("FAIL ops_res op=%b pred=%0d: valid=%b rsp=%h, expected o0o1=%b en=11",
                   ops[j], p, last_valid, last_rsp, want);
        end
      end
    end
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ops_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ops_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    set_lane(0, 4'h7, 4'h7, 3'b000, 1'b1);
    rsp_ready = 1'b0;
    req       = '1;
    repeat (2) tick();
    tick();
    n_checks++;
    if ({last_gnt, last_valid} !== {4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_full: gnt=%b valid=%b, expected gnt=0000 valid=1", last_gnt, last_valid);
    end
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (last_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_gnt_in_reset: gnt=%b, expected 0000", last_gnt);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({last_valid, last_gnt} !== {1'b0, 4'b0001}) begin
      n_fail++;
      $display("FAIL mid_after: valid=%b gnt=%b, expected valid=0 gnt=0001", last_valid, last_gnt);
    end
    req = '0;
    repeat (4) tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_sb: got %h, expected %h", o, e);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_pending: %0d responses missing, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
